// File: rtl/env_loader.sv
// -----------------------------------------------------------------------------
// env_loader
//
// Loads a GRID x GRID cell environment one row at a time into a shadow buffer
// and publishes it as a complete frame. The published frame and its live-cell
// count change only when a frame completes. The consumer acknowledges the
// frame before another load can begin.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   single-cycle request to begin loading (honoured in IDLE)
//   row_valid  in   row_data holds a valid row
//   row_ready  out  loader accepts a row this cycle (registered)
//   row_data   in   one row; bit j is column j, 1 = live
//   row_last   in   marks the final row of a frame
//   env_out    out  last completed frame; row i at [GRID*i +: GRID]
//   env_valid  out  env_out holds a complete frame awaiting consumption
//   env_ack    in   consumer has taken env_out (honoured in FULL)
//   pop_count  out  live-cell count of env_out
//   frame_err  out  one-cycle pulse when row_last disagrees with the row index
// -----------------------------------------------------------------------------
module env_loader #(
    parameter int GRID = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          row_valid,
    output logic                          row_ready,
    input  logic [GRID-1:0]               row_data,
    input  logic                          row_last,
    output logic [GRID*GRID-1:0]          env_out,
    output logic                          env_valid,
    input  logic                          env_ack,
    output logic [$clog2(GRID*GRID):0]    pop_count,
    output logic                          frame_err
);

    localparam int IDX_W = $clog2(GRID);
    localparam int POP_W = $clog2(GRID*GRID) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    // Registered state
    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [POP_W-1:0]       r_shadow_pop;
    logic [GRID*GRID-1:0]   r_env_out;
    logic [POP_W-1:0]       r_pop_count;
    logic                   r_env_valid;
    logic                   r_row_ready;
    logic                   r_frame_err;
    logic [GRID-1:0]        r_shadow [GRID];

    // Next-state values
    state_t                 w_state_nxt;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic [POP_W-1:0]       w_shadow_pop_nxt;
    logic [GRID*GRID-1:0]   w_env_out_nxt;
    logic [POP_W-1:0]       w_pop_count_nxt;
    logic                   w_env_valid_nxt;
    logic                   w_row_ready_nxt;
    logic                   w_frame_err_nxt;
    logic                   w_shadow_we;

    // Datapath helpers
    logic                   w_is_last_idx;
    logic [POP_W-1:0]       w_row_pop;
    logic [POP_W-1:0]       w_pop_sum;
    logic [GRID*GRID-1:0]   w_frame;

    function automatic logic [POP_W-1:0] f_popcount(input logic [GRID-1:0] v);
        logic [POP_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < GRID; i++) begin
            acc = acc + {{(POP_W-1){1'b0}}, v[i]};
        end
        return acc;
    endfunction

    always_comb begin
        w_is_last_idx = (r_idx == IDX_W'(GRID - 1));
        w_row_pop     = f_popcount(row_data);
        w_pop_sum     = r_shadow_pop + w_row_pop;
        // Completed frame: shadow rows, with the row arriving this cycle
        // substituted at the current index (it has not reached the shadow yet).
        w_frame       = '0;
        for (int i = 0; i < GRID; i++) begin
            w_frame[GRID*i +: GRID] = (IDX_W'(i) == r_idx) ? row_data : r_shadow[i];
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_shadow_pop_nxt = r_shadow_pop;
        w_env_out_nxt    = r_env_out;
        w_pop_count_nxt  = r_pop_count;
        w_frame_err_nxt  = 1'b0;
        w_shadow_we      = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt      = LOAD;
                    w_idx_nxt        = '0;
                    w_shadow_pop_nxt = '0;
                end
            end
            LOAD: begin
                // row_ready is high throughout LOAD, so row_valid alone accepts.
                if (row_valid) begin
                    w_shadow_we      = 1'b1;
                    w_shadow_pop_nxt = w_pop_sum;
                    if (w_is_last_idx) begin
                        // Frame completes regardless of row_last; a missing
                        // row_last is flagged but does not discard the frame.
                        w_env_out_nxt   = w_frame;
                        w_pop_count_nxt = w_pop_sum;
                        w_state_nxt     = FULL;
                        w_frame_err_nxt = ~row_last;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                        if (row_last) begin
                            // Early row_last: drop the partial frame.
                            w_frame_err_nxt = 1'b1;
                            w_state_nxt     = IDLE;
                        end
                    end
                end
            end
            FULL: begin
                if (env_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the next state decode.
        w_row_ready_nxt = (w_state_nxt == LOAD);
        w_env_valid_nxt = (w_state_nxt == FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_shadow_pop <= '0;
            r_env_out    <= '0;
            r_pop_count  <= '0;
            r_env_valid  <= 1'b0;
            r_row_ready  <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_shadow_pop <= w_shadow_pop_nxt;
            r_env_out    <= w_env_out_nxt;
            r_pop_count  <= w_pop_count_nxt;
            r_env_valid  <= w_env_valid_nxt;
            r_row_ready  <= w_row_ready_nxt;
            r_frame_err  <= w_frame_err_nxt;
        end
    end

    // Shadow contents need no reset: every row is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (w_shadow_we) begin
            r_shadow[r_idx] <= row_data;
        end
    end

    assign row_ready = r_row_ready;
    assign env_valid = r_env_valid;
    assign env_out   = r_env_out;
    assign pop_count = r_pop_count;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_env_loader.sv
// -----------------------------------------------------------------------------
// tb_env_loader
//
// Directed bench for env_loader at GRID=16. A frame-level model (queue-free
// row array, population from $countones over the finished frame) predicts
// every output; a compare process checks the DUT against it on each falling
// clock edge, and the stimulus sequence adds hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_env_loader;

    localparam int GRID  = 16;
    localparam int POP_W = 9;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               row_valid;
    logic               row_ready;
    logic [GRID-1:0]    row_data;
    logic               row_last;
    logic [255:0]       env_out;
    logic               env_valid;
    logic               env_ack;
    logic [POP_W-1:0]   pop_count;
    logic               frame_err;

    int checks = 0;
    int errors = 0;

    env_loader #(.GRID(GRID)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .row_last  (row_last),
        .env_out   (env_out),
        .env_valid (env_valid),
        .env_ack   (env_ack),
        .pop_count (pop_count),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_FULL = 2;

    int              m_state = M_IDLE;
    int              m_idx   = 0;
    logic [GRID-1:0] m_shadow [GRID];
    logic [GRID-1:0] m_env    [GRID];
    int              m_pop   = 0;
    logic            m_err   = 1'b0;

    initial begin
        for (int i = 0; i < GRID; i++) begin
            m_env[i]    = '0;
            m_shadow[i] = '0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_state = M_IDLE;
                m_idx   = 0;
                m_pop   = 0;
                m_err   = 1'b0;
                for (int i = 0; i < GRID; i++) m_env[i] = '0;
            end else begin
                m_err = 1'b0;
                if (m_state == M_IDLE) begin
                    if (start) begin
                        m_state = M_LOAD;
                        m_idx   = 0;
                    end
                end else if (m_state == M_LOAD) begin
                    if (row_valid) begin
                        m_shadow[m_idx] = row_data;
                        if (m_idx == GRID - 1) begin
                            m_pop = 0;
                            for (int i = 0; i < GRID; i++) begin
                                m_env[i] = m_shadow[i];
                                m_pop    = m_pop + $countones(m_shadow[i]);
                            end
                            m_state = M_FULL;
                            m_err   = !row_last;
                        end else begin
                            m_idx++;
                            if (row_last) begin
                                m_err   = 1'b1;
                                m_state = M_IDLE;
                            end
                        end
                    end
                end else begin
                    if (env_ack) m_state = M_IDLE;
                end
            end
        end
    end

    function automatic logic [255:0] model_env();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < GRID; i++) v[GRID*i +: GRID] = m_env[i];
        return v;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("row_ready", 256'(row_ready), 256'(m_state == M_LOAD));
        chk("env_valid", 256'(env_valid), 256'(m_state == M_FULL));
        chk("env_out", env_out, model_env());
        chk("pop_count", 256'(pop_count), 256'(m_pop));
        chk("frame_err", 256'(frame_err), 256'(m_err));
    end

    // ---------------- stimulus ----------------
    task automatic do_start();
        int n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!row_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_after_start", 256'(row_ready), 256'(1));
    endtask

    task automatic send_rows(input logic [GRID-1:0] d, input int count, input int last_at);
        for (int i = 0; i < count; i++) begin
            row_valid = 1'b1;
            row_data  = d;
            row_last  = (i == last_at);
            @(negedge clk);
        end
        row_valid = 1'b0;
        row_last  = 1'b0;
        row_data  = '0;
    endtask

    task automatic do_ack();
        env_ack = 1'b1;
        @(negedge clk);
        env_ack = 1'b0;
        chk("ack_to_idle", 256'(env_valid), 256'(0));
    endtask

    logic [255:0] pat_one;
    logic [255:0] pat_ff;

    initial begin
        int c;
        int acc;
        pat_one = {16{16'h0001}};
        pat_ff  = {16{16'hFFFF}};
        rst_n = 1'b0; start = 1'b0; row_valid = 1'b0; row_data = '0;
        row_last = 1'b0; env_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_env_out", env_out, 256'(0));
        chk("reset_pop", 256'(pop_count), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back 16 rows of 0001 with row_last on the 16th.
        do_start();
        send_rows(16'h0001, 16, 15);
        chk("b2b_env_valid", 256'(env_valid), 256'(1));
        chk("b2b_env_out", env_out, pat_one);
        chk("b2b_pop", 256'(pop_count), 256'(16));
        chk("b2b_no_err", 256'(frame_err), 256'(0));
        do_ack();

        // Same frame with row_valid toggling: completion 31 cycles after first accept.
        do_start();
        c = 0;
        acc = 0;
        while (!env_valid && c < 40) begin
            row_valid = (c % 2 == 0) && (acc < 16);
            row_data  = row_valid ? 16'h0001 : 16'h5A5A;
            row_last  = row_valid && (acc == 15);
            if (row_valid) acc++;
            @(negedge clk);
            c++;
        end
        row_valid = 1'b0; row_last = 1'b0; row_data = '0;
        chk("toggle_latency", 256'(c), 256'(31));
        chk("toggle_env_out", env_out, pat_one);
        chk("toggle_pop", 256'(pop_count), 256'(16));
        do_ack();

        // Early row_last on the 5th row: error, frame dropped, prior frame kept.
        do_start();
        send_rows(16'h00F0, 4, -1);
        row_valid = 1'b1; row_data = 16'h00F0; row_last = 1'b1;
        @(negedge clk);
        row_valid = 1'b0; row_last = 1'b0;
        chk("early_err_pulse", 256'(frame_err), 256'(1));
        chk("early_idle", 256'(row_ready), 256'(0));
        @(negedge clk);
        chk("early_err_clear", 256'(frame_err), 256'(0));
        chk("early_keep_env", env_out, pat_one);
        chk("early_keep_pop", 256'(pop_count), 256'(16));
        chk("early_no_valid", 256'(env_valid), 256'(0));

        // 16 rows of FFFF with no row_last: completes and flags.
        do_start();
        send_rows(16'hFFFF, 16, -1);
        chk("nolast_err_pulse", 256'(frame_err), 256'(1));
        chk("nolast_valid", 256'(env_valid), 256'(1));
        chk("nolast_pop", 256'(pop_count), 256'(256));
        chk("nolast_env", env_out, pat_ff);

        // start alone in FULL is ignored; start+ack returns to IDLE.
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_start_ign", 256'(env_valid), 256'(1));
        end
        env_ack = 1'b1;
        @(negedge clk);
        start = 1'b0; env_ack = 1'b0;
        chk("startack_valid", 256'(env_valid), 256'(0));
        chk("startack_idle", 256'(row_ready), 256'(0));
        @(negedge clk);
        chk("startack_still_idle", 256'(row_ready), 256'(0));

        // Asynchronous reset after 8 rows, then a fresh AAAA frame.
        do_start();
        send_rows(16'h5555, 8, -1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 256'(row_ready), 256'(0));
        chk("arst_env", env_out, 256'(0));
        chk("arst_pop", 256'(pop_count), 256'(0));
        chk("arst_valid", 256'(env_valid), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        row_valid = 1'b1; row_data = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        chk("arst_no_autoload", 256'(row_ready), 256'(0));
        row_valid = 1'b0; row_data = '0;
        do_start();
        send_rows(16'hAAAA, 16, 15);
        chk("aaaa_pop", 256'(pop_count), 256'(128));
        chk("aaaa_env", env_out, {16{16'hAAAA}});
        do_ack();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/env_loader.md
ENV_LOADER -- requirements
Module: env_loader

Interface
REQ-001 SHALL have parameter GRID, default 16, meaning grid rows and columns; all widths derive from it and verification uses 16.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  single-cycle request to begin loading a new environment.
REQ-005 SHALL have port row_valid  input  1  row_data holds a valid row.
REQ-006 SHALL have port row_ready  output  1  loader accepts a row this cycle.
REQ-007 SHALL have port row_data  input  GRID  one row; bit j is column j, 1 = live.
REQ-008 SHALL have port row_last  input  1  marks the final row of a frame.
REQ-009 SHALL have port env_out  output  GRID*GRID  last completed environment; row i at bits [GRID*i+GRID-1 : GRID*i].
REQ-010 SHALL have port env_valid  output  1  env_out holds a complete frame awaiting consumption.
REQ-011 SHALL have port env_ack  input  1  consumer has taken env_out.
REQ-012 SHALL have port pop_count  output  clog2(GRID*GRID)+1  live-cell count of env_out.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on row_last mismatch.
REQ-014 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-015 SHALL implement states IDLE, LOAD, FULL.
REQ-016 IDLE: row_ready=0, env_valid=0; start=1 -> LOAD, row index=0, shadow population=0.
REQ-017 LOAD: row_ready=1; a row is accepted on a clock edge where row_valid & row_ready.
REQ-018 Accepted row SHALL be written to shadow buffer row at current index; index increments; shadow population += popcount(row_data).
REQ-019 Rows SHALL be written into a shadow buffer; env_out and pop_count SHALL change only on frame completion.
REQ-020 Accepting row GRID-1 SHALL, on that same edge, copy shadow to env_out, load final population into pop_count, set env_valid=1, enter FULL.
REQ-021 row_last=1 on accepted row with index < GRID-1: frame_err pulses 1 cycle, shadow discarded, return to IDLE; env_out, pop_count unchanged.
REQ-022 row_last=0 on accepted row GRID-1: frame completes normally (REQ-020) and frame_err pulses 1 cycle.
REQ-023 FULL: row_ready=0, env_valid=1, env_out/pop_count stable; env_ack=1 -> IDLE, env_valid=0 next cycle.
REQ-024 start SHALL be ignored in LOAD and FULL; env_ack ignored outside FULL.
REQ-025 start and env_ack simultaneously in FULL: ack honoured, start ignored (IDLE next cycle).
REQ-026 row_valid without row_ready SHALL have no effect; row_data need not be held.
REQ-027 Population arithmetic SHALL be unsigned, never saturate; all-live grid yields 256 at GRID=16.
REQ-028 Row index SHALL never wrap within a frame; it resets to 0 on every entry to LOAD.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, row_ready=0, env_valid=0, env_out=0, pop_count=0, frame_err=0, shadow index=0.
REQ-030 Reset mid-LOAD SHALL discard partial frame; after release, only a fresh start begins loading.
REQ-031 Outputs SHALL be registered; no output depends combinationally on inputs.

Verification
REQ-032 Reset release, start, 16 rows 16'h0001 back-to-back, row_last on 16th -> env_valid=1 on edge of 16th accept, env_out bit 16*i = 1 for all i, pop_count=16.
REQ-033 Same load with row_valid toggling 1/0 each cycle -> exactly 16 accepts, identical env_out, completion 31 cycles after first accept.
REQ-034 row_last on 5th row -> frame_err 1 cycle, return IDLE, env_out/pop_count retain prior frame, env_valid=0.
REQ-035 16 rows 16'hFFFF, row_last never asserted -> frame_err pulse on 16th accept, env_valid=1, pop_count=256.
REQ-036 In FULL, drive start alone 3 cycles -> no state change; then start+env_ack together -> env_valid=0 next cycle, state IDLE.
REQ-037 rst_n low after 8 rows accepted -> all outputs 0 asynchronously; new start plus 16 rows 16'hAAAA -> pop_count=128.
